i2s_rx: RTL and testbench
=========================

# i2s_rx

I2S serial receiver: deserializes a standard I2S stream (bit clock, word select, serial data) into parallel left/right sample words. Sits at the audio input boundary, the receive-side counterpart of the I2S transmitter. It presents one registered left/right pair per stereo frame, flagged by a single-cycle valid pulse. The bit clock is the only clock; no clock-domain crossing is done here.

## Interface
- WIDTH, 16: sample word width per channel, in bits.
- WS_LEFT, 1'b0: ws_i level that denotes the left channel.
- sclk_i  in  1  bit clock; all logic on rising edge (transmitter drives on falling edge).
- rst_i  in  1  reset; one clock, synchronous, active-high.
- ws_i  in  1  word select from the transmitter.
- sdata_i  in  1  serial data, MSB first.
- leftChan_o  out  WIDTH  last complete left word.
- rightChan_o  out  WIDTH  last complete right word.
- valid_o  out  1  one-cycle pulse when a new L/R pair is presented.
- lenErr_o  out  1  one-cycle pulse, coincident with valid_o, if either slot length != WIDTH.

## Operation
- I2S framing: MSB of a word appears on sdata_i one sclk after the ws_i transition. The bit sampled on the edge where the ws transition is detected is the last bit of the previous word.
- ws_q holds ws_i from the previous edge. A ws transition is detected when ws_i != ws_q.
- Deserializer: cnt is the bit index within the current slot, 8 bits, saturating at 255.
  - Each edge with cnt < WIDTH: bit sdata_i is placed at position WIDTH-1-cnt of the word.
  - Bits beyond WIDTH are discarded (MSB-justified truncation).
  - If the slot has fewer than WIDTH bits, the unfilled LSBs are 0.
- On a detected transition:
  - The word, including the current bit, completes for channel ws_q.
  - The slot length is cnt+1.
  - cnt and the word register clear for the next slot.
- State machine (states SYNC, LEFT, RIGHT):
  - SYNC: entered on reset. Bits are ignored. On the first transition, go to LEFT or RIGHT per ws_i and discard the partial word.
  - LEFT: on a transition, store the word into the left holding register, set haveLeft, record the left length error, go to RIGHT.
  - RIGHT: on a transition, if haveLeft, load leftChan_o and rightChan_o, pulse valid_o, pulse lenErr_o if either slot length != WIDTH, then clear haveLeft. If haveLeft is clear, discard the word. Go to LEFT.
- The first frame after SYNC that starts in RIGHT produces no output. A frame is only emitted as an L-then-R pair.

## Timing
- Reset values: leftChan_o = 0, rightChan_o = 0, valid_o = 0, lenErr_o = 0, state = SYNC, cnt = 0, haveLeft = 0, ws_q <= ws_i (no false edge after reset).
- Latency: valid_o is high during the cycle after the edge that samples the right word's final bit (the edge detecting the R→L transition). Data outputs update on that same edge and hold until the next frame.
- valid_o never asserts on consecutive cycles. With WIDTH=16 and 16-bit slots, the minimum pulse spacing is 32 sclk.
- Reset mid-frame: partial words, haveLeft, and the pending error are discarded. No valid_o occurs until a full L then R pair after the next transition.
- Back-to-back transitions (1-bit slot) are legal: word = {bit, zeros}, and lenErr is set.
- Assertion of rst_i overrides all other events on the same edge.

## Structure
- Shared package i2s_pkg holds:
  - the state enum typedef (SYNC, LEFT, RIGHT);
  - the default WIDTH and WS_LEFT localparams;
  - the count width constant (8).
- One natural sub-module, i2s_word_deser: bit counter, MSB-first word assembly, truncate/pad, slot-length output. The top module holds ws edge detection, the FSM, the holding registers and the output registers.

## Test plan
- Nominal: WIDTH=16, 16-bit slots, L=16'hA5C3, R=16'h3C5A → leftChan_o=A5C3, rightChan_o=3C5A, valid_o one cycle, lenErr_o=0. Repeat 4 frames → 4 pulses spaced 32 sclk.
- Short slots of 12 bits, L=12'hABC, R=12'h123 → outputs 16'hABC0 / 16'h1230, lenErr_o=1 with valid_o.
- Long slots of 24 bits, L=24'hDEADBE, R=24'h012345 → outputs 16'hDEAD / 16'h0123, lenErr_o=1.
- Start mid-right-slot after reset → no valid_o for the first partial word or first R slot. First valid_o carries the first complete L/R pair.
- rst_i asserted for 1 cycle mid-left-slot → all outputs 0 next cycle, no valid_o for the interrupted frame, correct data on the following full frame.
- WS_LEFT=1 with L=16'h8001, R=16'h7FFE (ws high = left) → channels are not swapped.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receiver: FSM states, default
// parameters and the slot bit-counter width.
package i2s_pkg;

    typedef enum logic [1:0] {
        SYNC,
        LEFT,
        RIGHT
    } state_t;

    localparam int   DEFAULT_WIDTH   = 16;
    localparam logic DEFAULT_WS_LEFT = 1'b0;
    localparam int   CNT_W           = 8;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/i2s_rx_if.sv
// Serial input and parallel sample output bundle of the I2S receiver.
// The master side is the stream source / sample consumer, the slave side is i2s_rx.
interface i2s_rx_if #(
    parameter int WIDTH = 16
);
    logic             ws_i;
    logic             sdata_i;
    logic [WIDTH-1:0] leftChan_o;
    logic [WIDTH-1:0] rightChan_o;
    logic             valid_o;
    logic             lenErr_o;

    modport master (
        output ws_i,
        output sdata_i,
        input  leftChan_o,
        input  rightChan_o,
        input  valid_o,
        input  lenErr_o
    );

    modport slave (
        input  ws_i,
        input  sdata_i,
        output leftChan_o,
        output rightChan_o,
        output valid_o,
        output lenErr_o
    );
endinterface

// File: rtl/i2s_word_deser.sv
// MSB-first slot deserializer: counts bits in the current slot, keeps the first
// WIDTH bits and presents the word (including the current bit) plus slot length.
module i2s_word_deser
    import i2s_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sdata,
    input  logic             clear,
    output logic [WIDTH-1:0] word,
    output logic [CNT_W:0]   slot_len
);

    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] word_q;

    // NOTE: every output of a combinational block gets a default first, so no latch can be inferred.
    always_comb begin
        word     = word_q;
        slot_len = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(1);
        for (int i = 0; i < WIDTH; i++) begin
            if (CNT_W'(WIDTH - 1 - i) == cnt_q) begin
                word[i] = sdata;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= sat_inc(cnt_q);
            word_q <= word;
        end
    end

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver top: ws edge detection, SYNC/LEFT/RIGHT framing FSM, left holding
// register and registered L/R outputs with a one-cycle valid / length-error pulse.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int   WIDTH   = DEFAULT_WIDTH,
    parameter logic WS_LEFT = DEFAULT_WS_LEFT
) (
    input  logic    sclk_i,
    input  logic    rst_i,
    i2s_rx_if.slave bus
);

    state_t           state, next_state;
    logic             ws_q;
    logic             trans;
    logic [WIDTH-1:0] word;
    logic [CNT_W:0]   slot_len;
    logic             len_err_now;
    logic [WIDTH-1:0] left_hold;
    logic             left_err;
    logic             have_left;
    logic             store_left;
    logic             emit;

    assign trans       = bus.ws_i ^ ws_q;
    assign len_err_now = (slot_len != (CNT_W+1)'(WIDTH));

    i2s_word_deser #(
        .WIDTH (WIDTH)
    ) u_deser (
        .clk      (sclk_i),
        .rst      (rst_i),
        .sdata    (bus.sdata_i),
        .clear    (trans),
        .word     (word),
        .slot_len (slot_len)
    );

    always_ff @(posedge sclk_i) begin
        if (rst_i) state <= SYNC;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        store_left = 1'b0;
        emit       = 1'b0;
        case (state)
            SYNC: if (trans) next_state = (bus.ws_i == WS_LEFT) ? LEFT : RIGHT;
            LEFT: if (trans) begin
                store_left = 1'b1;
                next_state = RIGHT;
            end
            RIGHT: if (trans) begin
                emit       = have_left;
                next_state = LEFT;
            end
            default: next_state = SYNC;
        endcase
    end

    // Reload ws_q from the live input during reset so leaving reset is never seen as a ws edge.
    always_ff @(posedge sclk_i) begin
        if (rst_i) begin
            ws_q            <= bus.ws_i;
            have_left       <= 1'b0;
            left_hold       <= '0;
            left_err        <= 1'b0;
            bus.leftChan_o  <= '0;
            bus.rightChan_o <= '0;
            bus.valid_o     <= 1'b0;
            bus.lenErr_o    <= 1'b0;
        end else begin
            ws_q         <= bus.ws_i;
            bus.valid_o  <= emit;
            bus.lenErr_o <= emit & (left_err | len_err_now);
            if (store_left) begin
                left_hold <= word;
                left_err  <= len_err_now;
                have_left <= 1'b1;
            end
            if (emit) begin
                bus.leftChan_o  <= left_hold;
                bus.rightChan_o <= word;
                have_left       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: builds I2S bit streams slot by slot, plays them
// MSB first with ws leading by one bit, and checks the captured L/R pulses.
module tb_i2s_rx;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        e;
        int          cyc;
    } ev_t;

    logic sclk = 1'b0;
    logic rst  = 1'b1;
    logic ws   = 1'b0;
    logic sd   = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int dbl_valid    = 0;
    int orphan_err   = 0;
    logic prev_valid = 1'b0;

    ev_t ev0[$];
    ev_t ev1[$];
    bit  w_q[$];
    bit  d_q[$];

    always #5 sclk = ~sclk;

    i2s_rx_if #(.WIDTH(16)) bus0 ();
    i2s_rx_if #(.WIDTH(16)) bus1 ();

    assign bus0.ws_i    = ws;
    assign bus0.sdata_i = sd;
    assign bus1.ws_i    = ~ws;
    assign bus1.sdata_i = sd;

    i2s_rx #(.WIDTH(16), .WS_LEFT(1'b0)) dut0 (
        .sclk_i (sclk),
        .rst_i  (rst),
        .bus    (bus0)
    );

    i2s_rx #(.WIDTH(16), .WS_LEFT(1'b1)) dut1 (
        .sclk_i (sclk),
        .rst_i  (rst),
        .bus    (bus1)
    );

    always @(negedge sclk) begin
        cyc <= cyc + 1;
        prev_valid <= bus0.valid_o;
        if (bus0.valid_o && prev_valid)                dbl_valid  <= dbl_valid + 1;
        if (bus0.lenErr_o && !bus0.valid_o)            orphan_err <= orphan_err + 1;
        if (bus1.lenErr_o && !bus1.valid_o)            orphan_err <= orphan_err + 1;
        if (bus0.valid_o) ev0.push_back('{bus0.leftChan_o, bus0.rightChan_o, bus0.lenErr_o, cyc});
        if (bus1.valid_o) ev1.push_back('{bus1.leftChan_o, bus1.rightChan_o, bus1.lenErr_o, cyc});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_ev(input bit second, input int idx, input string tag,
                            input logic [15:0] l, input logic [15:0] r, input logic e);
        ev_t ev;
        if (!second && idx < ev0.size()) ev = ev0[idx];
        else if (second && idx < ev1.size()) ev = ev1[idx];
        else begin
            check({tag, "_present"}, 0, 1);
            return;
        end
        check({tag, "_left"},  {16'h0, ev.l}, {16'h0, l});
        check({tag, "_right"}, {16'h0, ev.r}, {16'h0, r});
        check({tag, "_err"},   {31'h0, ev.e}, {31'h0, e});
    endtask

    task automatic do_reset(input logic ws_lvl);
        @(negedge sclk);
        rst = 1'b1;
        ws  = ws_lvl;
        sd  = 1'b0;
        w_q.delete();
        d_q.delete();
        @(negedge sclk);
        rst = 1'b0;
        ev0.delete();
        ev1.delete();
    endtask

    task automatic push_slot(input bit wsl, input logic [31:0] data, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            w_q.push_back(wsl);
            d_q.push_back(data[i]);
        end
    endtask

    // Bit k is driven with the ws of bit k+1, so ws changes together with the previous word's LSB.
    task automatic play(input int rst_at);
        for (int k = 0; k < w_q.size(); k++) begin
            @(negedge sclk);
            rst = (k == rst_at);
            if (rst_at >= 0 && k == rst_at + 1) begin
                check("rst_left",  {16'h0, bus0.leftChan_o},  32'h0);
                check("rst_right", {16'h0, bus0.rightChan_o}, 32'h0);
                check("rst_valid", {31'h0, bus0.valid_o},     32'h0);
                check("rst_err",   {31'h0, bus0.lenErr_o},    32'h0);
            end
            ws = (k + 1 < w_q.size()) ? w_q[k+1] : w_q[k];
            sd = d_q[k];
        end
        repeat (4) @(negedge sclk);
    endtask

    initial begin
        // Reset state
        do_reset(1'b0);
        check("reset_left",  {16'h0, bus0.leftChan_o},  32'h0);
        check("reset_right", {16'h0, bus0.rightChan_o}, 32'h0);
        check("reset_valid", {31'h0, bus0.valid_o},     32'h0);
        check("reset_err",   {31'h0, bus0.lenErr_o},    32'h0);

        // Nominal: four 16-bit frames, pulses 32 sclk apart
        do_reset(1'b0);
        push_slot(1'b1, 32'hFFFF, 16);
        for (int f = 0; f < 4; f++) begin
            push_slot(1'b0, 32'hA5C3, 16);
            push_slot(1'b1, 32'h3C5A, 16);
        end
        push_slot(1'b0, 32'h0, 4);
        play(-1);
        check("nom_count", ev0.size(), 4);
        for (int i = 0; i < 4; i++) check_ev(1'b0, i, "nom", 16'hA5C3, 16'h3C5A, 1'b0);
        for (int i = 1; i < ev0.size(); i++) check("nom_spacing", ev0[i].cyc - ev0[i-1].cyc, 32);

        // Short 12-bit slots, then a 16-bit left with a 12-bit right
        do_reset(1'b0);
        push_slot(1'b1, 32'hFFFF, 16);
        push_slot(1'b0, 32'hABC, 12);
        push_slot(1'b1, 32'h123, 12);
        push_slot(1'b0, 32'hBEEF, 16);
        push_slot(1'b1, 32'h456, 12);
        push_slot(1'b0, 32'h0, 4);
        play(-1);
        check("short_count", ev0.size(), 2);
        check_ev(1'b0, 0, "short", 16'hABC0, 16'h1230, 1'b1);
        check_ev(1'b0, 1, "mixed", 16'hBEEF, 16'h4560, 1'b1);

        // Long 24-bit slots, then a 1-bit left slot (back-to-back ws edges)
        do_reset(1'b0);
        push_slot(1'b1, 32'hFFFF, 16);
        push_slot(1'b0, 32'hDEADBE, 24);
        push_slot(1'b1, 32'h012345, 24);
        push_slot(1'b0, 32'h1, 1);
        push_slot(1'b1, 32'h9876, 16);
        push_slot(1'b0, 32'h0, 4);
        play(-1);
        check("long_count", ev0.size(), 2);
        check_ev(1'b0, 0, "long", 16'hDEAD, 16'h0123, 1'b1);
        check_ev(1'b0, 1, "one_bit", 16'h8000, 16'h9876, 1'b1);

        // Start mid-right-slot: partial right word must not produce output
        do_reset(1'b1);
        push_slot(1'b1, 32'h55, 7);
        push_slot(1'b0, 32'h1111, 16);
        push_slot(1'b1, 32'h2222, 16);
        push_slot(1'b0, 32'h3333, 16);
        push_slot(1'b1, 32'h4444, 16);
        push_slot(1'b0, 32'h0, 4);
        play(-1);
        check("midr_count", ev0.size(), 2);
        check_ev(1'b0, 0, "midr_first", 16'h1111, 16'h2222, 1'b0);
        check_ev(1'b0, 1, "midr_second", 16'h3333, 16'h4444, 1'b0);

        // Reset pulse in the middle of a left slot
        do_reset(1'b0);
        push_slot(1'b1, 32'hFFFF, 16);
        push_slot(1'b0, 32'h1111, 16);
        push_slot(1'b1, 32'h2222, 16);
        push_slot(1'b0, 32'h1234, 16);
        push_slot(1'b1, 32'h5555, 16);
        push_slot(1'b0, 32'h6666, 16);
        push_slot(1'b1, 32'h7777, 16);
        push_slot(1'b0, 32'h0, 4);
        play(56);
        check("rstmid_count", ev0.size(), 2);
        check_ev(1'b0, 0, "rstmid_before", 16'h1111, 16'h2222, 1'b0);
        check_ev(1'b0, 1, "rstmid_after", 16'h6666, 16'h7777, 1'b0);

        // WS_LEFT=1 instance sees ws high on left slots; channels must not swap
        do_reset(1'b0);
        push_slot(1'b1, 32'hFFFF, 16);
        push_slot(1'b0, 32'h8001, 16);
        push_slot(1'b1, 32'h7FFE, 16);
        push_slot(1'b0, 32'h0, 4);
        play(-1);
        check("wsl0_count", ev0.size(), 1);
        check("wsl1_count", ev1.size(), 1);
        check_ev(1'b0, 0, "wsl0", 16'h8001, 16'h7FFE, 1'b0);
        check_ev(1'b1, 0, "wsl1", 16'h8001, 16'h7FFE, 1'b0);

        check("no_double_valid", dbl_valid, 0);
        check("no_orphan_err", orphan_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
